// File: rtl/write_buffer.sv
// write_buffer: posted-store FIFO between the cache controller and the SRAM controller.
// Define WB_FORWARD_EN to let loads hit buffered stores and bypass queued drains.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_W_EN,
  input  logic        MEM_R_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        empty,
  output logic        sram_w_en,
  output logic        sram_r_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, DRAIN, READ, GAP} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_addr_q [DEPTH];
  logic [31:0] mem_data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] count_q, count_d;
  logic [31:0] raddr_q, raddr_d;
  logic store, load, enq, deq, fwd_hit, load_go, read_done;
  logic [31:0] fwd_data;
  assign store = MEM_W_EN;
  assign load = MEM_R_EN & ~MEM_W_EN;
  assign empty = count_q == '0;
  assign enq = store & (count_q != FULL);
  assign deq = (state_q == DRAIN) & sram_ready;
  assign read_done = (state_q == READ) & sram_ready;
`ifdef WB_FORWARD_EN
  logic [PW-1:0] fwd_idx;
  // Walk oldest to newest so the youngest matching store wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if (((PW+1)'(k) < count_q) && (mem_addr_q[fwd_idx][31:2] == address[31:2])) begin
        fwd_hit = 1'b1;
        fwd_data = mem_data_q[fwd_idx];
      end
    end
  end
  assign load_go = load & ~fwd_hit;
`else
  assign fwd_hit = 1'b0;
  assign fwd_data = '0;
  assign load_go = load & empty;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      raddr_q <= raddr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_addr_q[tail_q] <= address;
      mem_data_q[tail_q] <= wdata;
    end
  end
  always_comb begin
    head_d = deq ? head_q + 1'b1 : head_q;
    tail_d = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (PW+1)'(enq) - (PW+1)'(deq);
    raddr_d = (state_q == IDLE && load_go) ? address : raddr_q;
  end
  // Loads take priority over drains; a started transaction always runs to sram_ready.
  always_comb begin
    state_d = state_q == IDLE ? (load_go ? READ : (empty ? IDLE : DRAIN))
            : state_q == GAP  ? IDLE
            : (sram_ready ? GAP : state_q);
  end
  always_comb begin
    sram_w_en = state_q == DRAIN;
    sram_r_en = state_q == READ;
    sram_address = state_q == DRAIN ? mem_addr_q[head_q] : (state_q == READ ? raddr_q : '0);
    sram_wdata = state_q == DRAIN ? mem_data_q[head_q] : '0;
    ready = rst & (store ? (count_q != FULL) : (load & (fwd_hit | read_done)));
    rdata = (load & fwd_hit) ? fwd_data : ((load & read_done) ? sram_rdata : '0);
  end
endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: table vectors for a single store plus scoreboarded drain/load/reset sequences.
module tb_write_buffer;
  logic clk = 1'b0, rst = 1'b0, MEM_W_EN = 1'b0, MEM_R_EN = 1'b0, sram_ready = 1'b0;
  logic [31:0] address = '0, wdata = '0, sram_rdata = '0;
  logic [31:0] rdata, sram_address, sram_wdata;
  logic ready, empty, sram_w_en, sram_r_en;
  logic act;
  int tests = 0, fails = 0;
  logic [63:0] exp_q[$];
  typedef struct {
    logic we; logic re; logic [31:0] a; logic [31:0] d; logic srdy;
    logic e_rdy; logic e_empty; logic e_wen; logic e_ren; logic [31:0] e_addr; logic [31:0] e_wdata;
  } vec_t;
  vec_t tv[7];
  write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .MEM_W_EN(MEM_W_EN), .MEM_R_EN(MEM_R_EN),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready), .empty(empty),
    .sram_w_en(sram_w_en), .sram_r_en(sram_r_en), .sram_address(sram_address),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] act_v, input logic [31:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act_v, exp_v);
    end
  endtask
  task automatic chk1(input string n, input logic act_v, input logic exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %b expected %b", n, act_v, exp_v);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    MEM_W_EN = 1'b1; address = a; wdata = d;
    exp_q.push_back({a, d});
    @(negedge clk);
    while (!ready && n < 50) begin tick(); @(negedge clk); n++; end
    chk1("store_ready", ready, 1'b1);
    tick();
    MEM_W_EN = 1'b0;
  endtask
  task automatic wait_wen();
    int n = 0;
    @(negedge clk);
    while (!sram_w_en && n < 50) begin tick(); @(negedge clk); n++; end
    chk1("drain_start", sram_w_en, 1'b1);
  endtask
  task automatic drain_one(input int lat);
    logic [63:0] e;
    wait_wen();
    chk1("sb_has_entry", exp_q.size() != 0, 1'b1);
    e = exp_q.size() != 0 ? exp_q[0] : '0;
    for (int i = 1; i <= lat; i++) begin
      chk1("drain_wen", sram_w_en, 1'b1);
      chk("drain_addr", sram_address, e[63:32]);
      chk("drain_data", sram_wdata, e[31:0]);
      if (i == lat) sram_ready = 1'b1;
      tick();
      if (i < lat) @(negedge clk);
    end
    sram_ready = 1'b0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
  endtask
  initial begin
    tv[0] = '{1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF};
    tv[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF};
    tv[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF};
    tv[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    // reset with a store request pending must still hold ready low
    MEM_W_EN = 1'b1; address = 32'h100; wdata = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_wen", sram_w_en, 1'b0);
    chk1("rst_ren", sram_r_en, 1'b0);
    chk("rst_saddr", sram_address, 32'h0);
    chk("rst_swdata", sram_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    MEM_W_EN = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      MEM_W_EN = tv[i].we; MEM_R_EN = tv[i].re; address = tv[i].a; wdata = tv[i].d; sram_ready = tv[i].srdy;
      @(negedge clk);
      chk1($sformatf("vec%0d_ready", i), ready, tv[i].e_rdy);
      chk1($sformatf("vec%0d_empty", i), empty, tv[i].e_empty);
      chk1($sformatf("vec%0d_wen", i), sram_w_en, tv[i].e_wen);
      chk1($sformatf("vec%0d_ren", i), sram_r_en, tv[i].e_ren);
      chk($sformatf("vec%0d_saddr", i), sram_address, tv[i].e_addr);
      chk($sformatf("vec%0d_swdata", i), sram_wdata, tv[i].e_wdata);
      chk($sformatf("vec%0d_rdata", i), rdata, 32'h0);
      tick();
    end
    sram_ready = 1'b0;
    // full buffer: fifth store stalls until the first drain completes
    for (int i = 0; i < 4; i++) put(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i));
    MEM_W_EN = 1'b1; address = 32'h1010; wdata = 32'hA4;
    exp_q.push_back({32'h1010, 32'hA4});
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk1("full_stall", ready, 1'b0); tick(); end
    drain_one(1);
    @(negedge clk);
    chk1("full_accept", ready, 1'b1);
    tick();
    MEM_W_EN = 1'b0;
    for (int i = 0; i < 4; i++) drain_one(2);
    @(negedge clk);
    chk1("full_empty_after", empty, 1'b1);
    chk("full_sb_drained", 32'(exp_q.size()), 32'h0);
    tick();
`ifdef WB_FORWARD_EN
    put(32'h200, 32'd1);
    put(32'h200, 32'd2);
    MEM_R_EN = 1'b1; address = 32'h203;
    @(negedge clk);
    chk1("fwd_ready", ready, 1'b1);
    chk("fwd_rdata", rdata, 32'd2);
    chk1("fwd_no_sram_read", sram_r_en, 1'b0);
    tick();
    MEM_R_EN = 1'b0;
    drain_one(1);
    drain_one(1);
`endif
    // load arriving mid-drain waits for the drain and the gap
    put(32'h400, 32'h0A);
    wait_wen();
    MEM_R_EN = 1'b1; address = 32'h300; sram_rdata = 32'h55;
    #1;
    chk1("load_wait_ready", ready, 1'b0);
    chk1("load_wait_ren", sram_r_en, 1'b0);
    drain_one(3);
    @(negedge clk);
    chk1("gap_ren", sram_r_en, 1'b0);
    chk1("gap_wen", sram_w_en, 1'b0);
    chk1("gap_ready", ready, 1'b0);
    tick();
    @(negedge clk);
    chk1("idle_ren", sram_r_en, 1'b0);
    tick();
    @(negedge clk);
    chk1("read_ren", sram_r_en, 1'b1);
    chk("read_addr", sram_address, 32'h300);
    chk1("read_wait_ready", ready, 1'b0);
    chk("read_wait_rdata", rdata, 32'h0);
    sram_ready = 1'b1;
    #1;
    chk1("read_ready", ready, 1'b1);
    chk("read_rdata", rdata, 32'h55);
    tick();
    sram_ready = 1'b0; MEM_R_EN = 1'b0;
    @(negedge clk);
    chk("read_rdata_after", rdata, 32'h0);
    chk1("read_ren_after", sram_r_en, 1'b0);
    tick();
    // reset mid-drain with three entries buffered
    put(32'h500, 32'hC0);
    put(32'h504, 32'hC1);
    put(32'h508, 32'hC2);
    wait_wen();
    rst = 1'b0;
    #1;
    chk1("mid_rst_wen", sram_w_en, 1'b0);
    chk1("mid_rst_ren", sram_r_en, 1'b0);
    chk1("mid_rst_empty", empty, 1'b1);
    chk1("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_saddr", sram_address, 32'h0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      act = act | sram_w_en | sram_r_en | ~empty;
      tick();
    end
    chk1("no_replay", act, 1'b0);
    // simultaneous enqueue and dequeue at count 2, pointers wrapping
    put(32'h600, 32'hB0);
    put(32'h604, 32'hB1);
    drain_one(1);
    put(32'h608, 32'hB2);
    wait_wen();
    MEM_W_EN = 1'b1; address = 32'h60C; wdata = 32'hB3;
    exp_q.push_back({32'h60C, 32'hB3});
    sram_ready = 1'b1;
    #1;
    chk1("simul_ready", ready, 1'b1);
    chk("simul_addr", sram_address, 32'h604);
    chk("simul_data", sram_wdata, 32'hB1);
    if (exp_q.size() != 0) exp_q.delete(0);
    tick();
    MEM_W_EN = 1'b0; sram_ready = 1'b0;
    @(negedge clk);
    chk1("simul_not_empty", empty, 1'b0);
    tick();
    put(32'h610, 32'hB4);
    for (int i = 0; i < 3; i++) drain_one(1);
    @(negedge clk);
    chk1("wrap_empty", empty, 1'b1);
    chk("wrap_sb_drained", 32'(exp_q.size()), 32'h0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
